// File: rtl/slot_arbiter_pkg.sv
// Shared types for the slot arbiter: FSM state encoding.
package slot_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin selector: finds the first set req bit after pointer,
// wrapping around so that pointer itself is checked last.
module rr_select #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned IDX_W      = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDX_W-1:0]      pointer,
    output logic                  valid,
    output logic [IDX_W-1:0]      index
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= REQUESTERS; i++) begin
            cand = IDX_W'((32'(pointer) + i) % REQUESTERS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/slot_arbiter.sv
// Round-robin time-slot arbiter: grants one requester for slot_max+1 enabled ticks.
// Optional macro SLOT_ARBITER_EARLY_RELEASE_EN ends a slot when the owner drops req.
module slot_arbiter
    import slot_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned IDX_W      = $clog2(REQUESTERS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [WIDTH-1:0]      max,
    input  logic [REQUESTERS-1:0] req,
    output logic [REQUESTERS-1:0] gnt,
    output logic [IDX_W-1:0]      idx,
    output logic [WIDTH-1:0]      cnt,
    output logic                  pls
);

    state_e                  state_q, state_d;
    logic [REQUESTERS-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        last_q, last_d;
    logic [WIDTH-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]        slot_max_q, slot_max_d;

    logic                    sel_valid;
    logic [IDX_W-1:0]        sel_idx;
    logic                    release_early;
    logic                    slot_end;

    rr_select #(
        .REQUESTERS (REQUESTERS),
        .IDX_W      (IDX_W)
    ) u_rr_select (
        .req     (req),
        .pointer (last_q),
        .valid   (sel_valid),
        .index   (sel_idx)
    );

    assign pls = (state_q == BUSY) && (cnt_q == slot_max_q);

`ifdef SLOT_ARBITER_EARLY_RELEASE_EN
    assign release_early = (state_q == BUSY) && !req[idx_q];
`else
    assign release_early = 1'b0;
`endif

    assign slot_end = (pls && ena) || release_early;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        slot_max_d = slot_max_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d    = BUSY;
                    gnt_d      = {{(REQUESTERS-1){1'b0}}, 1'b1} << sel_idx;
                    idx_d      = sel_idx;
                    last_d     = sel_idx;
                    cnt_d      = '0;
                    slot_max_d = max;
                end
            end
            BUSY: begin
                if (slot_end) begin
                    // Hand over in the same edge; a sole requester wins again via wrap.
                    if (sel_valid) begin
                        gnt_d      = {{(REQUESTERS-1){1'b0}}, 1'b1} << sel_idx;
                        idx_d      = sel_idx;
                        last_d     = sel_idx;
                        cnt_d      = '0;
                        slot_max_d = max;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end else if (ena) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            last_q     <= IDX_W'(REQUESTERS - 1);
            cnt_q      <= '0;
            slot_max_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            slot_max_q <= slot_max_d;
        end
    end

    assign gnt = gnt_q;
    assign idx = idx_q;
    assign cnt = cnt_q;

endmodule

// File: doc/slot_arbiter.md
SLOT_ARBITER -- requirements
Module: slot_arbiter

Interface
- REQ-001 Parameter REQUESTERS, default 4, number of requesters (2..16).
- REQ-002 Parameter WIDTH, default 4, slot counter width in bits.
- REQ-003 clk  input  1  system clock, all state updates on its rising edge.
- REQ-004 rst_n  input  1  reset; one clock, asynchronous, active-low.
- REQ-005 ena  input  1  slot timer tick enable.
- REQ-006 max  input  WIDTH  slot length minus one, in enabled ticks.
- REQ-007 req  input  REQUESTERS  per-requester access request, level-sensitive.
- REQ-008 gnt  output  REQUESTERS  registered one-hot grant, all-zero when idle.
- REQ-009 idx  output  $clog2(REQUESTERS)  index of granted requester, 0 when idle.
- REQ-010 cnt  output  WIDTH  current slot tick count.
- REQ-011 pls  output  1  last-tick indicator: busy and cnt equal to latched max.

Function
- REQ-012 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (one grant held).
- REQ-013 In IDLE with any req bit set, the next edge SHALL enter BUSY, set gnt to the round-robin winner, clear cnt, and latch max into slot_max; grant latency is 1 cycle.
- REQ-014 Round-robin search SHALL start at last granted index + 1 modulo REQUESTERS, so the last granted requester has lowest priority.
- REQ-015 In BUSY, cnt SHALL increment by 1 on each edge with ena=1 and hold when ena=0.
- REQ-016 pls SHALL be combinational: (state==BUSY) && (cnt==slot_max), independent of ena.
- REQ-017 On an edge with pls=1 and ena=1, the slot SHALL end: cnt clears to 0, and gnt moves to the next winner in the same edge (back-to-back, no idle cycle) or goes to zero and the FSM returns to IDLE if req is all-zero.
- REQ-018 A sole requester still asserting at slot end SHALL be re-granted back-to-back.
- REQ-019 max changes during BUSY SHALL affect only the next slot (slot_max is latched at each grant).
- REQ-020 With max=0 and ena=1, every slot SHALL last exactly 1 cycle.
- REQ-021 cnt SHALL never exceed slot_max; no wrap through 2**WIDTH occurs.
- REQ-022 Without early release (see Configuration), deassertion of the granted req SHALL NOT shorten the slot.

Reset
- REQ-023 rst_n=0 SHALL immediately force IDLE, gnt=0, idx=0, cnt=0, pls=0, slot_max=0, and last granted index = REQUESTERS-1, so requester 0 has top priority after reset.
- REQ-024 Reset asserted mid-slot SHALL abort the slot with no pls pulse; release SHALL be synchronous to clk.

Configuration
- REQ-025 Macro SLOT_ARBITER_EARLY_RELEASE_EN, when defined: in BUSY, req[idx]=0 at an edge SHALL end the slot at that edge exactly as in REQ-017, regardless of cnt or ena.
- REQ-026 When undefined, slot end SHALL occur only per REQ-017.

Structure
- REQ-027 Package slot_arbiter_pkg SHALL hold the state enum typedef (IDLE, BUSY).
- REQ-028 Combinational round-robin selector SHALL be sub-module rr_select, with inputs req and pointer and outputs valid and index.

Verification
- REQ-029 Reset: rst_n=0 mid-slot -> gnt=0000, cnt=0, pls=0 within the same cycle; after release, req=1111 -> gnt=0001.
- REQ-030 Single requester: req=0100, max=3, ena=1 -> gnt=0100 one cycle later, cnt 0,1,2,3, pls at cnt=3, re-granted back-to-back with cnt=0.
- REQ-031 Rotation: req=1111, max=0, ena=1 -> gnt 0001,0010,0100,1000,0001 on consecutive cycles, pls=1 every cycle.
- REQ-032 Enable gating: max=2, ena pattern 1,0,1,0,1 -> cnt 0,1,1,2,2 then slot ends; slot length is 3 enabled ticks.
- REQ-033 Max latching: max=5 at grant, changed to 1 at cnt=2 -> slot still ends at cnt=5; next slot ends at cnt=1.
- REQ-034 Early release: req=0011 with req[0] dropping at cnt=1, max=7 -> with macro, gnt=0010 next edge; without macro, gnt=0001 held until cnt=7.
